delay_arbiter: RTL
==================

# delay_arbiter

Round-robin arbiter and sequencer for one shared programmable down-counter. Up to NREQ requesters each ask for a timed interval of their own length. The block grants the counter to one requester at a time, runs the count, and reports completion with a single-cycle done pulse. It sits between the 50 MHz `clk` domain consumers, such as LED/blink and sequencing logic, and a single delay resource, so that each consumer does not need its own 28-bit counter.

## Interface
Parameters:
- NREQ, 4: number of requesters, range 2..8.
- CW, 28: counter and length width in bits.
- DIV, 1: prescale factor; the counter decrements once every DIV clocks. Range is 1..2^CW-1.

Ports:
- clk  in  1  system clock (50 MHz); all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock; removal is synchronous to `clk` by the system.
- req  in  NREQ  per-requester request level; the requester holds it high until its done pulse, or drops it to abort.
- len  in  NREQ*CW  packed lengths; requester i uses bits [i*CW +: CW].
- gnt  out  NREQ  one-hot grant; high for the whole interval of the served requester.
- done  out  NREQ  one-cycle completion pulse to the served requester.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, COUNT, GAP.
- Reset values:
  - state=IDLE
  - gnt=0, done=0, busy=0
  - ptr=0 (round-robin pointer)
  - cnt=0
  - pre=0 (prescaler count)
- IDLE, with any req bit high:
  - Select the first set req bit searching from ptr upward, wrapping modulo NREQ.
  - At that edge: sel<=i, gnt<=onehot(i), cnt<=len[i], pre<=DIV-1, ptr<=(i+1) mod NREQ, state<=COUNT.
- IDLE, with req all zero: hold; no change.
- len is sampled only at grant. Later changes to len[sel] are ignored until the next grant.
- COUNT: evaluate in this priority order.
  - req[sel]==0 (abort): gnt<=0, state<=IDLE, no done pulse. The pointer is already advanced.
  - pre!=0: pre<=pre-1.
  - pre==0 and cnt!=0: cnt<=cnt-1, pre<=DIV-1.
  - pre==0 and cnt==0: gnt<=0, done[sel]<=1, state<=GAP.
- GAP: lasts exactly one cycle.
  - done[sel] is high during it; done<=0 and state<=IDLE at the next edge.
  - req is not arbitrated in GAP. This gives the requester the done cycle to drop req.
- Other req bits may change freely at any time. Only req[sel] matters during COUNT.
- Arithmetic is unsigned, CW bits. cnt never underflows because the cnt==0 test precedes the decrement.
- Reset asserted in any state forces all reset values immediately: gnt and done drop asynchronously, and an interval in progress is lost with no done pulse.

## Timing
- Grant latency: if req[i] is high and state is IDLE before edge k, gnt[i] and busy are high after edge k.
- Interval: with length L, gnt is high for exactly (L+1)*DIV cycles. done is high for exactly one cycle, starting the cycle gnt falls.
- For DIV=1: gnt high for L+1 cycles, then done for 1 cycle, then IDLE for 1 cycle. The next grant is possible at the edge ending that IDLE cycle.
- Back-to-back throughput: one grant every (L+1)*DIV+2 cycles.
- L=0 is legal: gnt is high for DIV cycles, then done.
- Abort: dropping req[sel] is seen at the next edge. gnt falls after that edge, then IDLE for at least 1 cycle.
- gnt and done are never high in the same cycle. Both are registered with no combinational path from inputs.
- Fairness: a continuously requesting requester waits at most NREQ-1 other intervals.

## Test plan
- Single request, NREQ=4, DIV=1: req[2]=1 with len[2]=5 -> gnt=4'b0100 for 6 cycles, then done=4'b0100 for 1 cycle, busy low 1 cycle later. Requester drops req on done.
- Round-robin: all req=4'b1111, all len=2, held -> grant order 0,1,2,3,0. Period is 5 cycles per grant, and each done hits the correct bit.
- Zero length and prescale: DIV=3, req[1] with len=0 -> gnt for 3 cycles then done. DIV=3, len=2 -> gnt for 9 cycles.
- Abort: req[0] with len=100; drop req[0] on the 10th grant cycle -> gnt falls at the next edge, no done ever. Pending req[1] is then granted 2 edges later.
- Len change mid-interval: grant with len[3]=4, then write len[3]=50 during COUNT -> done still after 5 gnt cycles.
- Async reset mid-COUNT: pull rst_n low between edges -> gnt, done and busy go 0 immediately. After release with req[1]=1, the grant goes to 1 (ptr=0 search) with a full-length interval.

Source files
------------

// File: rtl/delay_arbiter_if.sv
// Handshake bundle between the delay consumers and the shared delay_arbiter.
// Consumers drive req/len through the master modport; the arbiter drives gnt/done/busy.
interface delay_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 28
);

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport master (
    output req,
    output len,
    input  gnt,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    input  len,
    output gnt,
    output done,
    output busy
  );

endinterface : delay_arbiter_if

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that time-shares one prescaled down-counter between NREQ
// requesters; each granted requester gets a (len+1)*DIV cycle interval and a done pulse.
module delay_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 28,
  parameter int DIV  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  delay_arbiter_if.slave bus
);

  localparam int            PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] PRE_RELOAD = CW'(DIV - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [PW-1:0]   sel_q,   sel_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [CW-1:0]   pre_q,   pre_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [NREQ-1:0] done_q,  done_d;

  logic [CW-1:0]   len_arr [NREQ];
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = bus.len[i*CW +: CW];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    gnt_d   = gnt_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          gnt_d   = onehot(pick);
          cnt_d   = len_arr[pick];
          pre_d   = PRE_RELOAD;
          ptr_d   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
          state_d = COUNT;
        end
      end

      // Abort outranks counting; the zero test on cnt precedes the decrement so it never wraps.
      COUNT: begin
        if (!bus.req[sel_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (pre_q != '0) begin
          pre_d = pre_q - 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          pre_d = PRE_RELOAD;
        end else begin
          gnt_d   = '0;
          done_d  = onehot(sel_q);
          state_d = GAP;
        end
      end

      // Single done cycle; no arbitration here so the requester can drop req.
      GAP: begin
        done_d  = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        done_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: every flop here is a control register, not storage, so all of them take the asynchronous reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      // NOTE: non-blocking updates make every register see the pre-edge values, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE);

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_gnt_done_excl : assert property (@(posedge clk) disable iff (!rst_n) !(|(gnt_q & done_q)));

endmodule : delay_arbiter
